// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard and its neighbours.
//
// Contents:
//   NREG, AW, CNTW    architectural register count, index width, counter width
//   CNT_MAX           largest number of in-flight writers per register
//   TOTW              width of the total in-flight writer count
//   REG_ZERO          index of the hardwired-zero register (never tracked)
//   reg_evt_t         {valid, rd} event pair shared with the forwarding and
//                     hazard blocks
//   evt_hits()        true when an event targets a given tracked register
package reg_scoreboard_pkg;

  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int CNTW    = 2;
  localparam int CNT_MAX = (1 << CNTW) - 1;
  localparam int TOTW    = $clog2((NREG - 1) * CNT_MAX + 1);

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef logic [AW-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } reg_evt_t;

  // x0 is never a real destination, so an event naming it hits nothing.
  function automatic logic evt_hits(reg_evt_t evt, reg_idx_t r);
    return evt.valid && (evt.rd == r) && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One per-register in-flight writer counter.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   inc_i           a new writer of this register is accepted this cycle
//   dec1_i          a writer of this register retires this cycle
//   dec2_i          a writer of this register is squashed this cycle
//   eff_o           count after this cycle's retire/squash, floored at 0
//   taken_o         how many of this cycle's decrements were really applied
//   underflow_o     decrements exceed the stored count
//
// eff_o must not depend on inc_i: the top derives stall (and hence inc_i)
// from eff_o, so the effective value and the next-state value are kept in
// separate combinational processes.
module sb_counter #(
  parameter int CNTW = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  input  logic            dec1_i,
  input  logic            dec2_i,
  output logic [CNTW-1:0] eff_o,
  output logic [CNTW-1:0] taken_o,
  output logic            underflow_o
);

  localparam logic [CNTW-1:0] MAX = '1;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW:0]   dec_x;

  // Effective count: stored value minus same-cycle retire and squash.
  always_comb begin
    dec_x       = {{CNTW{1'b0}}, dec1_i} + {{CNTW{1'b0}}, dec2_i};
    underflow_o = (dec_x > {1'b0, cnt_q});
    // With no underflow dec_x fits in CNTW bits, so truncation is exact.
    eff_o       = underflow_o ? '0 : (cnt_q - dec_x[CNTW-1:0]);
    taken_o     = cnt_q - eff_o;
  end

  // Next state: add the accepted issue; saturate rather than wrap.
  always_comb begin
    cnt_d = eff_o;
    if (inc_i && (eff_o != MAX)) begin
      cnt_d = eff_o + CNTW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Producer-side register hazard tracker sitting at ID.
//
// Counts in-flight writers per architectural register (x0 excluded), stalls
// issue while a source has an unretired writer or the destination counter is
// full, and reports when the pipeline holds no writers at all.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   issue_valid/regw/rd       presented instruction and its destination
//   issue_use_rs1/rs2, rs1/2  presented instruction's sources
//   wb_regw, wb_rd            retiring write at MEM/WB
//   sq_valid, sq_rd           one squashed in-flight writer
//   stall                     hold ID, do not issue
//   busy_rs1, busy_rs2        source has an outstanding writer after this
//                             cycle's retire/squash
//   idle                      no writers in flight
//   err                       sticky: a retire/squash found a zero counter
//
// Issue handshake: issue_valid is the offer and !stall is the ready. An
// instruction is accepted (and its destination counted) on a rising edge
// where issue_valid=1 and stall=0; while stall=1 the producer keeps the same
// instruction presented. stall depends combinationally on issue_* but never
// on anything registered downstream of the acceptance.
//
// The register file is write-first, so a retire in the same cycle as a
// dependent issue already resolves the hazard: every check uses the
// effective count after that cycle's retire and squash.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic          issue_regw,
  input  logic [AW-1:0] issue_rd,
  input  logic          issue_use_rs1,
  input  logic          issue_use_rs2,
  input  logic [AW-1:0] issue_rs1,
  input  logic [AW-1:0] issue_rs2,
  input  logic          wb_regw,
  input  logic [AW-1:0] wb_rd,
  input  logic          sq_valid,
  input  logic [AW-1:0] sq_rd,
  output logic          stall,
  output logic          busy_rs1,
  output logic          busy_rs2,
  output logic          idle,
  output logic          err
);

  localparam logic [CNTW-1:0] FULL = CNTW'(CNT_MAX);

  reg_evt_t wb_evt, sq_evt;

  logic [CNTW-1:0] eff_w   [NREG];
  logic [CNTW-1:0] taken_w [NREG];
  logic [NREG-1:0] unf_w;
  logic [NREG-1:0] inc_w, dec1_w, dec2_w;

  logic            full;
  logic            accept;
  logic            inc_any;
  logic [TOTW-1:0] dec_total;
  logic [TOTW-1:0] total_q, total_d;
  logic            err_q, err_d;

  assign wb_evt = '{valid: wb_regw,  rd: wb_rd};
  assign sq_evt = '{valid: sq_valid, rd: sq_rd};

  // x0 has no counter; it reads as permanently empty.
  assign eff_w[0]   = '0;
  assign taken_w[0] = '0;
  assign unf_w[0]   = 1'b0;

  // Retire/squash decode, independent of the issue side.
  always_comb begin
    dec1_w = '0;
    dec2_w = '0;
    for (int r = 1; r < NREG; r++) begin
      dec1_w[r] = evt_hits(wb_evt, reg_idx_t'(r));
      dec2_w[r] = evt_hits(sq_evt, reg_idx_t'(r));
    end
  end

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    sb_counter #(.CNTW(CNTW)) u_cnt (
      .clk_i       (clk),
      .rst_ni      (rst),
      .inc_i       (inc_w[g]),
      .dec1_i      (dec1_w[g]),
      .dec2_i      (dec2_w[g]),
      .eff_o       (eff_w[g]),
      .taken_o     (taken_w[g]),
      .underflow_o (unf_w[g])
    );
  end

  // Hazard checks against the effective counts.
  always_comb begin
    busy_rs1 = issue_use_rs1 && (issue_rs1 != REG_ZERO) && (eff_w[issue_rs1] != '0);
    busy_rs2 = issue_use_rs2 && (issue_rs2 != REG_ZERO) && (eff_w[issue_rs2] != '0);
    full     = issue_regw && (issue_rd != REG_ZERO) && (eff_w[issue_rd] == FULL);
    stall    = issue_valid && (busy_rs1 || busy_rs2 || full);
    accept   = issue_valid && !stall;
    inc_any  = accept && issue_regw && (issue_rd != REG_ZERO);
  end

  always_comb begin
    inc_w = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_w[r] = inc_any && (issue_rd == reg_idx_t'(r));
    end
  end

  // Only the applied decrements leave the total. When retire and squash
  // name the same register, taken_w of that register already covers both.
  always_comb begin
    dec_total = '0;
    if (wb_regw) begin
      dec_total = TOTW'(taken_w[wb_rd]);
    end
    if (sq_valid && !(wb_regw && (wb_rd == sq_rd))) begin
      dec_total = dec_total + TOTW'(taken_w[sq_rd]);
    end
    total_d = total_q + TOTW'(inc_any) - dec_total;
    err_d   = err_q || (|unf_w);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  assign idle = (total_q == '0);
  assign err  = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  localparam int NREG = 32;
  localparam int MAXC = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       issue_valid = 1'b0;
  logic       issue_regw = 1'b0;
  logic [4:0] issue_rd = '0;
  logic       issue_use_rs1 = 1'b0;
  logic       issue_use_rs2 = 1'b0;
  logic [4:0] issue_rs1 = '0;
  logic [4:0] issue_rs2 = '0;
  logic       wb_regw = 1'b0;
  logic [4:0] wb_rd = '0;
  logic       sq_valid = 1'b0;
  logic [4:0] sq_rd = '0;
  logic       stall, busy_rs1, busy_rs2, idle, err;

  reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_regw    (issue_regw),
    .issue_rd      (issue_rd),
    .issue_use_rs1 (issue_use_rs1),
    .issue_use_rs2 (issue_use_rs2),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .wb_regw       (wb_regw),
    .wb_rd         (wb_rd),
    .sq_valid      (sq_valid),
    .sq_rd         (sq_rd),
    .stall         (stall),
    .busy_rs1      (busy_rs1),
    .busy_rs2      (busy_rs2),
    .idle          (idle),
    .err           (err)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  int cnt_m [NREG] = '{default: 0};
  int total_m = 0;
  bit err_m = 1'b0;

  function automatic int eff_m(int r);
    int e;
    if (r == 0) return 0;
    e = cnt_m[r] - int'(wb_regw && wb_rd == r) - int'(sq_valid && sq_rd == r);
    return (e < 0) ? 0 : e;
  endfunction

  function automatic bit exp_busy1();
    return issue_use_rs1 && issue_rs1 != 0 && eff_m(int'(issue_rs1)) > 0;
  endfunction

  function automatic bit exp_busy2();
    return issue_use_rs2 && issue_rs2 != 0 && eff_m(int'(issue_rs2)) > 0;
  endfunction

  function automatic bit exp_stall();
    bit full;
    full = issue_regw && issue_rd != 0 && eff_m(int'(issue_rd)) == MAXC;
    return issue_valid && (exp_busy1() || exp_busy2() || full);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
      total_m = 0;
      err_m   = 1'b0;
    end else begin
      bit acc;
      acc = issue_valid && !exp_stall();
      for (int r = 1; r < NREG; r++) begin
        int d;
        d = int'(wb_regw && wb_rd == r) + int'(sq_valid && sq_rd == r);
        if (d > cnt_m[r]) begin
          err_m = 1'b1;
          total_m -= cnt_m[r];
          cnt_m[r] = 0;
        end else begin
          cnt_m[r] -= d;
          total_m  -= d;
        end
        if (acc && issue_regw && issue_rd == r) begin
          cnt_m[r]++;
          total_m++;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic chk(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_stall", stall, exp_stall());
    chk("model_busy_rs1", busy_rs1, exp_busy1());
    chk("model_busy_rs2", busy_rs2, exp_busy2());
    chk("model_idle", idle, total_m == 0);
    chk("model_err", err, err_m);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    issue_valid = 0; issue_regw = 0; issue_rd = 0;
    issue_use_rs1 = 0; issue_use_rs2 = 0; issue_rs1 = 0; issue_rs2 = 0;
    wb_regw = 0; wb_rd = 0; sq_valid = 0; sq_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic present_write(input logic [4:0] rd);
    issue_valid = 1; issue_regw = 1; issue_rd = rd;
  endtask

  task automatic present_read1(input logic [4:0] rs);
    issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = rs;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 0;
    clear_in();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  function automatic logic [4:0] pick_active();
    logic [4:0] live[$];
    for (int r = 1; r < NREG; r++) if (cnt_m[r] > 0) live.push_back(5'(r));
    if (live.size() == 0 || $urandom_range(0, 19) == 0)
      return 5'($urandom_range(0, 7));
    return live[$urandom_range(0, live.size() - 1)];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy1", busy_rs1, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // Writer of x5, then a reader saved by a same-cycle retire.
    present_write(5'd5);
    #2 chk("t1_issue_stall", stall, 1'b0);
    tick();
    #2 chk("t1_idle_low", idle, 1'b0);
    present_read1(5'd5);
    #1 chk("t1_raw_stall", stall, 1'b1);
    wb_regw = 1; wb_rd = 5'd5;
    #1 chk("t1_wb_bypass", stall, 1'b0);
    chk("t1_wb_busy", busy_rs1, 1'b0);
    tick();
    present_read1(5'd5);
    #2 chk("t1_cnt_zero", stall, 1'b0);
    chk("t1_idle_back", idle, 1'b1);
    tick();

    // x0 is never tracked.
    repeat (3) begin
      present_write(5'd0);
      tick();
    end
    issue_valid = 1; issue_use_rs2 = 1; issue_rs2 = 5'd0;
    #2 chk("t2_x0_stall", stall, 1'b0);
    chk("t2_x0_idle", idle, 1'b1);
    tick();

    // Fill x7, then the fourth writer hits the full limit.
    repeat (3) begin
      present_write(5'd7);
      #2 chk("t3_fill_stall", stall, 1'b0);
      tick();
    end
    present_write(5'd7);
    #2 chk("t3_full_stall", stall, 1'b1);
    wb_regw = 1; wb_rd = 5'd7;
    #1 chk("t3_full_wb", stall, 1'b0);
    tick();
    present_write(5'd7);
    #2 chk("t3_still_full", stall, 1'b1);
    clear_in();
    repeat (3) begin
      wb_regw = 1; wb_rd = 5'd7;
      tick();
    end
    #1 chk("t3_drained", idle, 1'b1);

    // Squash two writers.
    present_write(5'd9);
    tick();
    present_write(5'd10);
    tick();
    sq_valid = 1; sq_rd = 5'd9;
    tick();
    sq_valid = 1; sq_rd = 5'd10;
    tick();
    present_read1(5'd9);
    #2 chk("t4_sq_idle", idle, 1'b1);
    chk("t4_sq_err", err, 1'b0);
    chk("t4_sq_stall", stall, 1'b0);
    tick();

    // Retire with nothing in flight.
    wb_regw = 1; wb_rd = 5'd12;
    tick();
    #1 chk("t5_err_set", err, 1'b1);
    chk("t5_idle", idle, 1'b1);
    repeat (3) tick();
    chk("t5_err_sticky", err, 1'b1);
    rst = 0;
    #1 chk("t5_err_clr", err, 1'b0);
    rst = 1;
    tick();

    // Asynchronous reset mid-cycle with x3 holding two writers.
    present_write(5'd3);
    tick();
    present_write(5'd3);
    tick();
    present_read1(5'd3);
    #2 chk("t6_pre_stall", stall, 1'b1);
    chk("t6_pre_idle", idle, 1'b0);
    rst = 0;
    #1 chk("t6_async_idle", idle, 1'b1);
    chk("t6_async_stall", stall, 1'b0);
    tick();
    rst = 1;
    tick();

    // Randomised traffic in segments separated by resets.
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 600; c++) begin
        issue_valid   = ($urandom_range(0, 9) < 7);
        issue_regw    = ($urandom_range(0, 9) < 6);
        issue_rd      = 5'($urandom_range(0, 7));
        issue_use_rs1 = $urandom_range(0, 1);
        issue_use_rs2 = $urandom_range(0, 1);
        issue_rs1     = 5'($urandom_range(0, 7));
        issue_rs2     = 5'($urandom_range(0, 7));
        wb_regw       = ($urandom_range(0, 9) < 4);
        wb_rd         = pick_active();
        sq_valid      = ($urandom_range(0, 9) < 2);
        sq_rd         = pick_active();
        @(posedge clk);
        #1;
      end
      do_reset();
    end

    clear_in();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
